// File: rtl/ifu_fetch_bus_pkg.sv
// Shared definitions for the instruction-fetch bus master: FSM encodings,
// AXI response codes and the default reset PC.
package ifu_fetch_bus_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_bus.sv
// Instruction-fetch master: one AXI4-Lite read per instruction, handed to decode
// over valid/ready. Optional access-fault reporting under CONFIG_IFU_ACCESS_FAULT_EN.
module ifu_fetch_bus
    import ifu_fetch_bus_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        m_valid,
    input  logic        m_ready
`ifdef CONFIG_IFU_ACCESS_FAULT_EN
    ,
    output logic        fault_F
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_next_q, pc_next_d;
    logic         kill_q, kill_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  snpcf_q, snpcf_d;
    logic         fault_q, fault_d;
    logic         resp_err;
    logic [31:0]  redir_aligned;

    assign redir_aligned = align_pc(redirect_pc);

`ifdef CONFIG_IFU_ACCESS_FAULT_EN
    assign resp_err = (rresp != AXI_RESP_OKAY);
    assign fault_F  = fault_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign resp_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_START;
            pc_q      <= RESET_PC;
            pc_next_q <= RESET_PC;
            kill_q    <= 1'b0;
            inst_q    <= 32'h0;
            pcf_q     <= RESET_PC;
            snpcf_q   <= RESET_PC + 32'd4;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            pcf_q     <= pcf_d;
            snpcf_q   <= snpcf_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        pcf_d     = pcf_q;
        snpcf_d   = snpcf_q;
        fault_d   = fault_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        m_valid   = 1'b0;

        unique case (state_q)
            ST_START: begin
                if (redirect_valid) pc_d = redir_aligned;
                state_d = ST_AR;
            end
            ST_AR: begin
                arvalid = 1'b1;
                // araddr must stay put until the handshake, so a redirect is parked.
                if (redirect_valid) begin
                    kill_d    = 1'b1;
                    pc_next_d = redir_aligned;
                end
                if (arready) state_d = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (redirect_valid) begin
                    kill_d    = 1'b1;
                    pc_next_d = redir_aligned;
                end
                if (rvalid) begin
                    if (kill_q || redirect_valid) begin
                        pc_d    = redirect_valid ? redir_aligned : pc_next_q;
                        kill_d  = 1'b0;
                        state_d = ST_AR;
                    end else begin
                        inst_d  = resp_err ? INST_NOP : rdata;
                        fault_d = resp_err;
                        pcf_d   = pc_q;
                        snpcf_d = pc_q + 32'd4;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                m_valid = 1'b1;
                // A redirect wins over the sequential PC even if decode accepts.
                if (redirect_valid) begin
                    pc_d    = redir_aligned;
                    state_d = ST_AR;
                end else if (m_ready) begin
                    pc_d    = snpcf_q;
                    state_d = ST_AR;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    assign araddr = pc_q;
    assign instF  = inst_q;
    assign pcF    = pcf_q;
    assign snpcF  = snpcf_q;

endmodule

// File: tb/tb_ifu_fetch_bus.sv
// Directed bench for ifu_fetch_bus: table of fetch transactions plus
// hand-written redirect and reset sequences.
module tb_ifu_fetch_bus;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic [31:0] snpcF;
    logic        m_valid;
    logic        m_ready;
`ifdef CONFIG_IFU_ACCESS_FAULT_EN
    logic        fault_F;
`endif

    int total = 0;
    int bad   = 0;

    ifu_fetch_bus dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .instF          (instF),
        .pcF            (pcF),
        .snpcF          (snpcF),
        .m_valid        (m_valid),
        .m_ready        (m_ready)
`ifdef CONFIG_IFU_ACCESS_FAULT_EN
        ,
        .fault_F        (fault_F)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ar_wait;
        logic [31:0] data;
        logic [1:0]  resp;
        int          hold;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_ar();
        int n = 0;
        while (!arvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("arvalid_timeout", {31'h0, arvalid}, 32'h1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
        chk("rst_rready",  {31'h0, rready},  32'h0);
        chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_araddr",  araddr, 32'h8000_0000);
        chk("rst_pcF",     pcF,    32'h8000_0000);
        chk("rst_snpcF",   snpcF,  32'h8000_0004);
        chk("rst_instF",   instF,  32'h0);
`ifdef CONFIG_IFU_ACCESS_FAULT_EN
        chk("rst_fault", {31'h0, fault_F}, 32'h0);
`endif
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int ar_wait,
                            input logic [31:0] data, input logic [1:0] resp,
                            input int hold, input logic [31:0] exp_inst,
                            input logic exp_fault, input logic redir,
                            input logic [31:0] rpc);
        wait_ar();
        chk("ar_addr", araddr, addr);
        chk("ar_no_rready", {31'h0, rready}, 32'h0);
        for (int i = 0; i < ar_wait; i++) begin
            arready = 1'b0;
            @(negedge clk);
            chk("ar_wait_valid", {31'h0, arvalid}, 32'h1);
            chk("ar_wait_addr", araddr, addr);
            chk("ar_wait_rready", {31'h0, rready}, 32'h0);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("r_rready", {31'h0, rready}, 32'h1);
        chk("r_arvalid", {31'h0, arvalid}, 32'h0);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        @(negedge clk);
        rvalid = 1'b0;
        rresp  = 2'b00;
        chk("hold_m_valid", {31'h0, m_valid}, 32'h1);
        chk("hold_instF", instF, exp_inst);
        chk("hold_pcF", pcF, addr);
        chk("hold_snpcF", snpcF, addr + 32'd4);
`ifdef CONFIG_IFU_ACCESS_FAULT_EN
        chk("hold_fault", {31'h0, fault_F}, {31'h0, exp_fault});
`else
        if (exp_fault) chk("fault_unexpected_in_table", 32'h0, 32'h1);
`endif
        for (int i = 0; i < hold; i++) begin
            m_ready = 1'b0;
            @(negedge clk);
            chk("stall_m_valid", {31'h0, m_valid}, 32'h1);
            chk("stall_instF", instF, exp_inst);
            chk("stall_pcF", pcF, addr);
            chk("stall_arvalid", {31'h0, arvalid}, 32'h0);
        end
        m_ready        = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(negedge clk);
        m_ready        = 1'b0;
        redirect_valid = 1'b0;
        chk("acc_m_valid", {31'h0, m_valid}, 32'h0);
        chk("acc_arvalid", {31'h0, arvalid}, 32'h1);
        chk("acc_next_addr", araddr, redir ? {rpc[31:2], 2'b00} : addr + 32'd4);
    endtask

    initial begin
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        arready = 1'b0;
        rdata = 32'h0;
        rresp = 2'b00;
        rvalid = 1'b0;
        m_ready = 1'b0;

        vecs[0] = '{32'h8000_0000, 0, 32'h0010_0093, 2'b00, 5, 32'h0010_0093, 1'b0};
        vecs[1] = '{32'h8000_0004, 3, 32'h0020_0113, 2'b00, 0, 32'h0020_0113, 1'b0};
`ifdef CONFIG_IFU_ACCESS_FAULT_EN
        vecs[2] = '{32'h8000_0008, 1, 32'hDEAD_BEEF, 2'b10, 2, 32'h0000_0013, 1'b1};
`else
        vecs[2] = '{32'h8000_0008, 1, 32'hDEAD_BEEF, 2'b10, 2, 32'hDEAD_BEEF, 1'b0};
`endif
        vecs[3] = '{32'h8000_000C, 0, 32'h1234_5678, 2'b00, 0, 32'h1234_5678, 1'b0};

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b1;

        for (int v = 0; v < 4; v++)
            do_fetch(vecs[v].addr, vecs[v].ar_wait, vecs[v].data, vecs[v].resp,
                     vecs[v].hold, vecs[v].exp_inst, vecs[v].exp_fault, 1'b0, 32'h0);

        // redirect in R, same cycle as rvalid: response dropped
        wait_ar();
        chk("sa_addr", araddr, 32'h8000_0010);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'hBAD0_0001;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0101;
        @(negedge clk);
        rvalid = 1'b0;
        redirect_valid = 1'b0;
        chk("sa_m_valid", {31'h0, m_valid}, 32'h0);
        chk("sa_arvalid", {31'h0, arvalid}, 32'h1);
        chk("sa_addr_redir", araddr, 32'h8000_0100);
        do_fetch(32'h8000_0100, 0, 32'h0030_0193, 2'b00, 0, 32'h0030_0193, 1'b0, 1'b0, 32'h0);

        // two redirects in AR: address held, newest target wins
        wait_ar();
        chk("sb_addr", araddr, 32'h8000_0104);
        arready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0300;
        @(negedge clk);
        chk("sb_addr_held", araddr, 32'h8000_0104);
        chk("sb_arvalid_held", {31'h0, arvalid}, 32'h1);
        redirect_pc = 32'h8000_0400;
        arready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        arready = 1'b0;
        chk("sb_rready", {31'h0, rready}, 32'h1);
        @(negedge clk);
        chk("sb_wait_no_m_valid", {31'h0, m_valid}, 32'h0);
        rvalid = 1'b1;
        rdata = 32'hBAD0_0002;
        @(negedge clk);
        rvalid = 1'b0;
        chk("sb_m_valid", {31'h0, m_valid}, 32'h0);
        chk("sb_addr_redir", araddr, 32'h8000_0400);

        // redirect in HOLD with m_ready the same cycle
        do_fetch(32'h8000_0400, 0, 32'h0040_0213, 2'b00, 1, 32'h0040_0213, 1'b0, 1'b1, 32'h8000_0200);
        do_fetch(32'h8000_0200, 0, 32'h0050_0293, 2'b00, 0, 32'h0050_0293, 1'b0, 1'b0, 32'h0);

        // async reset mid-read, then redirect during START
        wait_ar();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0502;
        rst = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("sc_arvalid", {31'h0, arvalid}, 32'h1);
        chk("sc_addr", araddr, 32'h8000_0500);
        do_fetch(32'h8000_0500, 0, 32'h0060_0313, 2'b00, 0, 32'h0060_0313, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    always @(negedge clk) begin
        if (rst && arvalid && rready) begin
            total++;
            bad++;
            $display("FAIL arvalid_rready_overlap: got 1 want 0");
        end
    end

endmodule
